// File: rtl/systolic_array_pkg.sv
// Shared sizing constants and operand/accumulator types for the systolic MAC array
// and the A/B transpose buffers that feed it.
package systolic_array_pkg;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;

  typedef logic signed [BITS_AB-1:0] ab_t;
  typedef logic signed [BITS_C-1:0]  c_t;
endpackage

// File: rtl/tpumac.sv
// One processing element: forwards operands east/south and accumulates their product.
module tpumac
  import systolic_array_pkg::*;
#(
  parameter int BITS_AB = systolic_array_pkg::BITS_AB,
  parameter int BITS_C  = systolic_array_pkg::BITS_C
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);
  logic signed [BITS_AB-1:0]   a_q, b_q;
  logic signed [BITS_C-1:0]    acc_q, acc_d;
  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]    prod_ext;

  assign prod     = Ain * Bin;
  // Signed size cast: sign-extends when the accumulator is wider, truncates otherwise.
  assign prod_ext = BITS_C'(prod);

  always_comb begin
    acc_d = acc_q;
    if (WrEn)    acc_d = Cin;
    else if (en) acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      if (en) begin
        a_q <= Ain;
        b_q <= Bin;
      end
      acc_q <= acc_d;
    end
  end

  assign Aout = a_q;
  assign Bout = b_q;
  assign Cout = acc_q;
endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary MAC array: A flows east, B flows south, each PE keeps
// its own accumulator; one row is loaded or read back at a time via Crow.
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int BITS_AB = systolic_array_pkg::BITS_AB,
  parameter int BITS_C  = systolic_array_pkg::BITS_C,
  parameter int DIM     = systolic_array_pkg::DIM
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       WrEn,
  input  logic signed [BITS_AB-1:0]  A    [DIM],
  input  logic signed [BITS_AB-1:0]  B    [DIM],
  input  logic signed [BITS_C-1:0]   Cin  [DIM],
  input  logic [$clog2(DIM)-1:0]     Crow,
  output logic signed [BITS_C-1:0]   Cout [DIM]
);
  // a_w[r][c] / b_w[r][c] are the operand inputs of PE(r,c).
  logic signed [BITS_AB-1:0] a_w [DIM][DIM];
  logic signed [BITS_AB-1:0] b_w [DIM][DIM];
  logic signed [BITS_C-1:0]  acc_w [DIM][DIM];
  // Operands leaving the east and south edges have no consumer.
  logic signed [BITS_AB-1:0] a_east_unused  [DIM];
  logic signed [BITS_AB-1:0] b_south_unused [DIM];

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic signed [BITS_AB-1:0] a_out, b_out;
      logic                      wr_pe;

      if (c == 0) begin : g_a_edge
        assign a_w[r][c] = A[r];
      end
      if (r == 0) begin : g_b_edge
        assign b_w[r][c] = B[c];
      end

      if (c < DIM-1) begin : g_a_fwd
        assign a_w[r][c+1] = a_out;
      end else begin : g_a_sink
        assign a_east_unused[r] = a_out;
      end
      if (r < DIM-1) begin : g_b_fwd
        assign b_w[r+1][c] = b_out;
      end else begin : g_b_sink
        assign b_south_unused[c] = b_out;
      end

      assign wr_pe = WrEn && (Crow == ($clog2(DIM))'(r));

      tpumac #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .WrEn  (wr_pe),
        .Ain   (a_w[r][c]),
        .Bin   (b_w[r][c]),
        .Cin   (Cin[c]),
        .Aout  (a_out),
        .Bout  (b_out),
        .Cout  (acc_w[r][c])
      );
    end
  end

  always_comb begin
    for (int c = 0; c < DIM; c++) begin
      Cout[c] = acc_w[Crow][c];
    end
  end
endmodule

// File: doc/systolic_array.md
# systolic_array

DIM×DIM weight-stationary-free (output-stationary) systolic multiply-accumulate array. It consumes the row-skewed A operand stream produced by the A-matrix transpose buffer (one signed BITS_AB value per row per cycle) and the column-skewed B operand stream from the B-side buffer. It accumulates C = A×B in place, one accumulator per processing element. Results are loaded or read back one row at a time.

## Interface
- BITS_AB, 8: width of signed A/B operands.
- BITS_C, 16: width of signed accumulators.
- DIM, 8: array dimension (rows = columns = DIM).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance: shift operands one hop and accumulate.
- WrEn  in  1  load Cin into accumulators of row Crow.
- A  in  signed [BITS_AB-1:0] ×DIM  A[r] enters PE(r,0).
- B  in  signed [BITS_AB-1:0] ×DIM  B[c] enters PE(0,c).
- Cin  in  signed [BITS_C-1:0] ×DIM  load data, Cin[c] → PE(Crow,c).
- Crow  in  $clog2(DIM)  row select for load and readback.
- Cout  out  signed [BITS_C-1:0] ×DIM  accumulators of row Crow.

## Operation
- Each PE(r,c) holds three registers: a_q (BITS_AB), b_q (BITS_AB), acc (BITS_C).
- Operand inputs:
  - PE(r,c) A input is A[r] when c=0, otherwise PE(r,c-1).a_q.
  - PE(r,c) B input is B[c] when r=0, otherwise PE(r-1,c).b_q.
- When en=1, every PE updates:
  - a_q ← a_in;
  - b_q ← b_in;
  - acc ← acc + sext(a_in × b_in).
- Arithmetic:
  - The product is a full 2·BITS_AB-bit signed multiply, sign-extended or truncated to BITS_C.
  - The sum wraps modulo 2^BITS_C. There is no saturation and no overflow flag.
- When WrEn=1, PE(Crow,c).acc ← Cin[c] for all c. This overrides accumulation in that row for that cycle. It applies regardless of en.
- When WrEn=1 and en=1 together:
  - row Crow still shifts a_q/b_q;
  - all other rows accumulate normally.
- When en=0 and WrEn=0, all state holds.
- Cout[c] = PE(Crow,c).acc. This is a combinational read of current register state, with no read latency.
- Clearing is done by driving WrEn with Cin=0 for each row, i.e. DIM cycles. There is no global clear other than reset.

## Timing
- Reset (async assert, sync release): all a_q, b_q and acc are 0. Cout therefore reads 0 for every Crow.
- Operand hop latency: 1 en-cycle per PE. A[r] reaches PE(r,c) input after c enabled cycles; B[c] reaches PE(r,c) input after r enabled cycles.
- Upstream skew contract:
  - A[r] must be presented delayed r cycles relative to row 0.
  - B[c] must be presented delayed c cycles relative to column 0.
  - Under this skew, A[r][k] and B[k][c] coincide at PE(r,c).
- With skewed inputs and accumulators cleared, Cout is the full product 3·DIM−2 enabled cycles after the first (k=0) operands are presented to PE(0,0).
- Zero-padding outside the valid window (supplied by upstream) leaves acc unchanged.
- Boundaries:
  - Deasserting en mid-computation freezes the wavefront. Resuming produces the identical result.
  - Reset mid-computation clears everything immediately.
  - Crow changes take effect on Cout in the same cycle.

## Structure
- Shared package: default BITS_AB, BITS_C, DIM constants and the operand/accumulator typedefs (ab_t, c_t). These are shared with the A/B transpose buffers.
- One sub-module, `tpumac`: a single PE holding a_q, b_q and acc. It has ports Ain, Bin, Cin, en, WrEn, Aout, Bout, Cout. It is instantiated DIM×DIM via nested generate loops; WrEn to each PE is WrEn && (Crow==r).
- Interconnect: two DIM×DIM arrays of operand wires.

## Test plan
- **Reset:** Assert rst_n=0 mid-run, then sweep Crow 0..7 → every Cout[c]=0 immediately after reset.
- **Load/readback:** WrEn with Crow=3, Cin[c]=c−4, en=0. Read Crow=3 → Cout={−4..3}. Other rows still 0.
- **Single MAC:**
  - Stimulus: A[0]=3, B[0]=−5, en=1 for one cycle, other inputs 0.
  - Response: PE(0,0).acc=−15.
  - The next cycle with zero inputs leaves it at −15; PE(0,1) and PE(1,0) stay 0.
- **Full product:** Skewed 8×8 identity × random signed B, then 3·DIM−2=22 en-cycles → each row r reads B row r exactly. Repeat with random A against a golden model.
- **Wrap-around:** A=127, B=127 at PE(0,0) for 3 cycles from acc=0 → 48387 mod 2^16 = −17149.
- **Stall/priority:**
  - Drop en for 5 cycles mid-product → final result is identical to the unstalled run.
  - WrEn to row 2 concurrent with en=1 → row 2 = Cin, while row 1 accumulates.
